syn_lb_demux_n: RTL and testbench

- Parametrised local-bus (LB) address decoder and response arbiter. It fans one LB master out to NUM_SLAVES slave LB ports.
- Sits at a subsystem top (vcortex, acortex, etc.) and replaces ad-hoc hand-decoding there.
- Unlike the combinational split, it registers the request and tracks exactly one outstanding transaction.
- It also times out silent slaves and returns error responses for unmapped or illegal accesses.

---
 rtl/syn_lb_pkg.sv | 45 ++++
 rtl/syn_lb_timeout_cntr.sv | 29 ++
 rtl/syn_lb_demux_n.sv | 222 ++++++++++++++++++++++
 tb/tb_syn_lb_demux_n.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/syn_lb_pkg.sv
// Shared types, constants and the block-code decoder for the local-bus demux.
package syn_lb_pkg;

  localparam int unsigned LB_MAX_SLAVES = 16;
  localparam int unsigned LB_MAX_CODE_W = 16;
  localparam int unsigned LB_IDX_W      = 4;
  localparam int unsigned LB_CODES_W    = LB_MAX_SLAVES * LB_MAX_CODE_W;

  localparam logic [31:0] LB_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lb_fsm_t;

  typedef struct packed {
    logic                hit;
    logic [LB_IDX_W-1:0] idx;
  } lb_dec_t;

  // Lowest slave whose code slice matches wins; slices beyond num are ignored.
  function automatic lb_dec_t lb_decode(
    input logic [LB_MAX_CODE_W-1:0] code,
    input logic [LB_CODES_W-1:0]    codes,
    input int unsigned              num,
    input int unsigned              code_w
  );
    lb_dec_t                  res;
    logic [LB_MAX_CODE_W-1:0] mask;
    logic [LB_MAX_CODE_W-1:0] slice;
    res  = '0;
    mask = LB_MAX_CODE_W'((32'd1 << code_w) - 32'd1);
    for (int unsigned i = 0; i < LB_MAX_SLAVES; i++) begin
      slice = LB_MAX_CODE_W'(codes >> (i * code_w)) & mask;
      if (!res.hit && (i < num) && (slice == (code & mask))) begin
        res.hit = 1'b1;
        res.idx = LB_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/syn_lb_timeout_cntr.sv
// Clearable up-counter that flags the last allowed cycle of a slave wait.
module syn_lb_timeout_cntr #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_ir,
  input  logic rst_sync_l,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired_c = en && (count == LAST);

endmodule

// File: rtl/syn_lb_demux_n.sv
// Registered local-bus demux: decodes a block code, issues to one slave,
// waits for its response with a timeout and returns data or an error.
module syn_lb_demux_n
  import syn_lb_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES  = 4,
  parameter int unsigned                  DATA_W      = 32,
  parameter int unsigned                  ADDR_W      = 12,
  parameter int unsigned                  CODE_W      = 4,
  parameter int unsigned                  SLV_ADDR_W  = 8,
  parameter logic [NUM_SLAVES*CODE_W-1:0] SLAVE_CODES = {4'd3, 4'd2, 4'd1, 4'd0},
  parameter int unsigned                  TIMEOUT_W   = 8,
  parameter int unsigned                  TIMEOUT_VAL = 255,
  parameter logic [DATA_W-1:0]            ERR_DATA    = DATA_W'(LB_ERR_DATA)
) (
  input  logic                         clk_ir,
  input  logic                         rst_sync_l,
  input  logic                         m_rd_en,
  input  logic                         m_wr_en,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wr_data,
  output logic                         m_rd_valid,
  output logic                         m_wr_valid,
  output logic [DATA_W-1:0]            m_rd_data,
  output logic                         m_err,
  output logic                         busy,
  output logic [NUM_SLAVES-1:0]        s_rd_en,
  output logic [NUM_SLAVES-1:0]        s_wr_en,
  output logic [SLV_ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]            s_wr_data,
  input  logic [NUM_SLAVES-1:0]        s_rd_valid,
  input  logic [NUM_SLAVES-1:0]        s_wr_valid,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rd_data,
  output logic                         err_timeout,
  output logic                         err_unmapped,
  output logic [7:0]                   stray_cnt
);

  lb_fsm_t state_q, state_d;

  // Latched transaction
  logic                wr_q;
  logic                err_q;
  logic                unm_q;
  logic [LB_IDX_W-1:0] idx_q;

  logic                start_c, both_c, acc_c, stray_c, to_expired_c;
  logic [CODE_W-1:0]   code_c;
  lb_dec_t             dec_c;
  logic [NUM_SLAVES-1:0] dec_oh_c, sel_oh_c, rd_mask_c, wr_mask_c;
  logic [DATA_W-1:0]   slave_rdata_c;

  // Next values for registered outputs and latch controls
  logic                lat_en, lat_wr, lat_err, lat_unm;
  logic [NUM_SLAVES-1:0] s_rd_en_d, s_wr_en_d;
  logic                rd_valid_d, wr_valid_d, m_err_d, err_to_d, err_unm_d;
  logic                rdata_en;
  logic [DATA_W-1:0]   rdata_d;

  assign start_c = m_rd_en | m_wr_en;
  assign both_c  = m_rd_en & m_wr_en;
  assign code_c  = m_addr[ADDR_W-1 -: CODE_W];
  assign dec_c   = lb_decode(LB_MAX_CODE_W'(code_c), LB_CODES_W'(SLAVE_CODES),
                             NUM_SLAVES, CODE_W);

  // One-hot views of the decoded and latched slave index, plus its read data
  always_comb begin
    dec_oh_c      = '0;
    sel_oh_c      = '0;
    slave_rdata_c = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      dec_oh_c[i] = (dec_c.idx == LB_IDX_W'(i));
      sel_oh_c[i] = (idx_q == LB_IDX_W'(i));
      if (idx_q == LB_IDX_W'(i)) begin
        slave_rdata_c = s_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the selected slave's valid in the latched direction is accepted in WAIT
  assign rd_mask_c = ((state_q == WAIT) && !wr_q) ? sel_oh_c : '0;
  assign wr_mask_c = ((state_q == WAIT) &&  wr_q) ? sel_oh_c : '0;
  assign acc_c     = |(s_rd_valid & rd_mask_c) | |(s_wr_valid & wr_mask_c);
  assign stray_c   = |(s_rd_valid & ~rd_mask_c) | |(s_wr_valid & ~wr_mask_c);

  syn_lb_timeout_cntr #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT_VAL)
  ) u_timeout (
    .clk_ir     (clk_ir),
    .rst_sync_l (rst_sync_l),
    .clr        (state_q == ISSUE),
    .en         (state_q == WAIT),
    .expired_c  (to_expired_c)
  );

  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Error transactions pass through ISSUE without a slave strobe so that
  // their response lands two cycles after the master strobe.
  always_comb begin
    state_d    = state_q;
    lat_en     = 1'b0;
    lat_wr     = 1'b0;
    lat_err    = 1'b0;
    lat_unm    = 1'b0;
    s_rd_en_d  = '0;
    s_wr_en_d  = '0;
    rd_valid_d = 1'b0;
    wr_valid_d = 1'b0;
    m_err_d    = 1'b0;
    err_to_d   = 1'b0;
    err_unm_d  = 1'b0;
    rdata_en   = 1'b0;
    rdata_d    = slave_rdata_c;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          lat_en  = 1'b1;
          lat_wr  = m_wr_en & ~m_rd_en;
          state_d = ISSUE;
          if (both_c) begin
            lat_err = 1'b1;
          end else if (!dec_c.hit) begin
            lat_err = 1'b1;
            lat_unm = 1'b1;
          end else if (m_wr_en) begin
            s_wr_en_d = dec_oh_c;
          end else begin
            s_rd_en_d = dec_oh_c;
          end
        end
      end
      ISSUE: begin
        if (err_q) begin
          state_d    = RESP;
          rd_valid_d = !wr_q;
          wr_valid_d = wr_q;
          m_err_d    = 1'b1;
          err_unm_d  = unm_q;
          rdata_en   = 1'b1;
          rdata_d    = ERR_DATA;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (acc_c) begin
          state_d    = RESP;
          rd_valid_d = !wr_q;
          wr_valid_d = wr_q;
          rdata_en   = !wr_q;
        end else if (to_expired_c) begin
          state_d    = RESP;
          rd_valid_d = !wr_q;
          wr_valid_d = wr_q;
          m_err_d    = 1'b1;
          err_to_d   = 1'b1;
          rdata_en   = 1'b1;
          rdata_d    = ERR_DATA;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      unm_q        <= 1'b0;
      idx_q        <= '0;
      s_addr       <= '0;
      s_wr_data    <= '0;
      s_rd_en      <= '0;
      s_wr_en      <= '0;
      m_rd_valid   <= 1'b0;
      m_wr_valid   <= 1'b0;
      m_err        <= 1'b0;
      m_rd_data    <= '0;
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
      busy         <= 1'b0;
      stray_cnt    <= '0;
    end else begin
      if (lat_en) begin
        wr_q      <= lat_wr;
        err_q     <= lat_err;
        unm_q     <= lat_unm;
        idx_q     <= dec_c.idx;
        s_addr    <= m_addr[SLV_ADDR_W-1:0];
        s_wr_data <= m_wr_data;
      end
      s_rd_en      <= s_rd_en_d;
      s_wr_en      <= s_wr_en_d;
      m_rd_valid   <= rd_valid_d;
      m_wr_valid   <= wr_valid_d;
      m_err        <= m_err_d;
      err_timeout  <= err_to_d;
      err_unmapped <= err_unm_d;
      busy         <= (state_d != IDLE);
      if (rdata_en) begin
        m_rd_data <= rdata_d;
      end
      if (stray_c && (stray_cnt != 8'hFF)) begin
        stray_cnt <= stray_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_syn_lb_demux_n.sv
// Directed bench for syn_lb_demux_n: a table of single transactions plus
// hand sequences for timeout, strobes while busy and reset mid-transaction.
module tb_syn_lb_demux_n;

  logic         clk_ir = 1'b0;
  logic         rst_sync_l;
  logic         m_rd_en, m_wr_en;
  logic [11:0]  m_addr;
  logic [31:0]  m_wr_data;
  logic         m_rd_valid, m_wr_valid, m_err, busy;
  logic [31:0]  m_rd_data;
  logic [3:0]   s_rd_en, s_wr_en;
  logic [7:0]   s_addr;
  logic [31:0]  s_wr_data;
  logic [3:0]   s_rd_valid, s_wr_valid;
  logic [127:0] s_rd_data;
  logic         err_timeout, err_unmapped;
  logic [7:0]   stray_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] JUNK = 128'h4444_4444_3333_3333_2222_2222_1111_1111;

  syn_lb_demux_n dut (
    .clk_ir       (clk_ir),
    .rst_sync_l   (rst_sync_l),
    .m_rd_en      (m_rd_en),
    .m_wr_en      (m_wr_en),
    .m_addr       (m_addr),
    .m_wr_data    (m_wr_data),
    .m_rd_valid   (m_rd_valid),
    .m_wr_valid   (m_wr_valid),
    .m_rd_data    (m_rd_data),
    .m_err        (m_err),
    .busy         (busy),
    .s_rd_en      (s_rd_en),
    .s_wr_en      (s_wr_en),
    .s_addr       (s_addr),
    .s_wr_data    (s_wr_data),
    .s_rd_valid   (s_rd_valid),
    .s_wr_valid   (s_wr_valid),
    .s_rd_data    (s_rd_data),
    .err_timeout  (err_timeout),
    .err_unmapped (err_unmapped),
    .stray_cnt    (stray_cnt)
  );

  always #5 clk_ir = ~clk_ir;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          k;
    int          slave;
    logic [31:0] rdata;
    logic [3:0]  exp_rd_en;
    logic [3:0]  exp_wr_en;
    logic        exp_rv;
    logic        exp_wv;
    logic        exp_err;
    logic        exp_unm;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Strobe at cycle T; slave answers at T+k; response expected at T+k+1
  // (or at T+2 for error transactions).
  task automatic run_vec(input vec_t v);
    logic early;
    early     = 1'b0;
    m_rd_en   = v.rd;
    m_wr_en   = v.wr;
    m_addr    = v.addr;
    m_wr_data = v.wdata;
    s_rd_data = JUNK;
    step();
    m_rd_en = 1'b0;
    m_wr_en = 1'b0;
    chk({v.name, ":s_rd_en"}, 32'(s_rd_en), 32'(v.exp_rd_en));
    chk({v.name, ":s_wr_en"}, 32'(s_wr_en), 32'(v.exp_wr_en));
    chk({v.name, ":busy_t1"}, 32'(busy), 32'd1);
    if (!v.exp_err) begin
      chk({v.name, ":s_addr"}, 32'(s_addr), 32'(v.addr[7:0]));
      if (v.wr) chk({v.name, ":s_wr_data"}, s_wr_data, v.wdata);
      for (int c = 1; c < v.k; c++) begin
        step();
        early = early | m_rd_valid | m_wr_valid;
      end
      if (v.wr) begin
        s_wr_valid[v.slave] = 1'b1;
      end else begin
        s_rd_valid[v.slave] = 1'b1;
        s_rd_data[v.slave*32 +: 32] = v.rdata;
      end
      step();
      s_rd_valid = '0;
      s_wr_valid = '0;
      chk({v.name, ":early_resp"}, 32'(early), 32'd0);
    end else begin
      step();
    end
    chk({v.name, ":m_rd_valid"}, 32'(m_rd_valid), 32'(v.exp_rv));
    chk({v.name, ":m_wr_valid"}, 32'(m_wr_valid), 32'(v.exp_wv));
    chk({v.name, ":m_err"}, 32'(m_err), 32'(v.exp_err));
    chk({v.name, ":err_unmapped"}, 32'(err_unmapped), 32'(v.exp_unm));
    chk({v.name, ":err_timeout"}, 32'(err_timeout), 32'd0);
    if (v.exp_rv) chk({v.name, ":m_rd_data"}, m_rd_data, v.exp_rdata);
    step();
    chk({v.name, ":busy_after"}, 32'(busy), 32'd0);
    chk({v.name, ":valid_after"}, 32'({m_rd_valid, m_wr_valid}), 32'd0);
  endtask

  initial begin
    int nresp;
    logic seen;
    //             name      rd    wr    addr     wdata          k  slv rdata          rd_en    wr_en    rv    wv    err   unm   rdata
    vecs[0] = '{"rd_s2",   1'b1, 1'b0, 12'h210, 32'h0,         4, 2, 32'hCAFE0001, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE0001};
    vecs[1] = '{"wr_s1",   1'b0, 1'b1, 12'h104, 32'h55,        4, 1, 32'h0,        4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{"rd_unm",  1'b1, 1'b0, 12'hF00, 32'h0,         0, 0, 32'h0,        4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{"rd_s3k2", 1'b1, 1'b0, 12'h3AB, 32'h0,         2, 3, 32'h12345678, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[4] = '{"wr_s0k6", 1'b0, 1'b1, 12'h0FF, 32'hA0A00001,  6, 0, 32'h0,        4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{"both",    1'b1, 1'b1, 12'h100, 32'h0,         0, 0, 32'h0,        4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[6] = '{"rd_s0k3", 1'b1, 1'b0, 12'h042, 32'h0,         3, 0, 32'hA5A5A5A5, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5A5A5};
    vecs[7] = '{"wr_unm",  1'b0, 1'b1, 12'h533, 32'h77,        0, 0, 32'h0,        4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0};

    rst_sync_l = 1'b0;
    m_rd_en    = 1'b0;
    m_wr_en    = 1'b0;
    m_addr     = '0;
    m_wr_data  = '0;
    s_rd_valid = '0;
    s_wr_valid = '0;
    s_rd_data  = JUNK;
    step();
    step();
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:strobes", 32'({s_rd_en, s_wr_en}), 32'd0);
    chk("reset:m_rd_data", m_rd_data, 32'd0);
    chk("reset:stray_cnt", 32'(stray_cnt), 32'd0);
    rst_sync_l = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Slave 0 never answers: error response exactly 255 WAIT cycles later
    m_rd_en = 1'b1;
    m_addr  = 12'h000;
    step();
    m_rd_en = 1'b0;
    chk("to:s_rd_en", 32'(s_rd_en), 32'b0001);
    seen = 1'b0;
    for (int c = 2; c <= 256; c++) begin
      step();
      seen = seen | m_rd_valid | err_timeout;
    end
    chk("to:no_early", 32'(seen), 32'd0);
    step();
    chk("to:m_rd_valid", 32'(m_rd_valid), 32'd1);
    chk("to:m_err", 32'(m_err), 32'd1);
    chk("to:err_timeout", 32'(err_timeout), 32'd1);
    chk("to:m_rd_data", m_rd_data, 32'hDEADBEEF);
    step();
    chk("to:busy_after", 32'(busy), 32'd0);
    s_rd_valid[0] = 1'b1;
    step();
    s_rd_valid = '0;
    chk("to:stray_cnt", 32'(stray_cnt), 32'd1);
    chk("to:late_no_resp", 32'(m_rd_valid), 32'd0);
    step();

    // Write strobe while the read to slave 2 is waiting is dropped
    m_rd_en = 1'b1;
    m_addr  = 12'h220;
    step();
    m_rd_en = 1'b0;
    chk("ovl:s_rd_en", 32'(s_rd_en), 32'b0100);
    step();
    m_wr_en   = 1'b1;
    m_addr    = 12'h100;
    m_wr_data = 32'h99;
    step();
    m_wr_en = 1'b0;
    chk("ovl:no_strobe", 32'({s_rd_en, s_wr_en}), 32'd0);
    chk("ovl:busy", 32'(busy), 32'd1);
    s_rd_valid[2] = 1'b1;
    s_rd_data[64 +: 32] = 32'hBEEF0002;
    step();
    s_rd_valid = '0;
    chk("ovl:m_rd_valid", 32'(m_rd_valid), 32'd1);
    chk("ovl:m_rd_data", m_rd_data, 32'hBEEF0002);
    nresp = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      nresp += int'(m_rd_valid) + int'(m_wr_valid) + int'(|s_wr_en);
    end
    chk("ovl:single_resp", 32'(nresp), 32'd0);
    chk("ovl:stray_kept", 32'(stray_cnt), 32'd1);

    // Reset during WAIT clears everything; a fresh read then works
    m_rd_en = 1'b1;
    m_addr  = 12'h300;
    step();
    m_rd_en = 1'b0;
    step();
    rst_sync_l = 1'b0;
    step();
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:strobes", 32'({s_rd_en, s_wr_en}), 32'd0);
    chk("rst:m_rd_data", m_rd_data, 32'd0);
    chk("rst:stray_cnt", 32'(stray_cnt), 32'd0);
    chk("rst:s_addr", 32'(s_addr), 32'd0);
    rst_sync_l = 1'b1;
    step();
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
